tdc_meas_ctrl: RTL and testbench
================================

TDC_MEAS_CTRL -- requirements
Module: tdc_meas_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk100 (all logic on rising edge) and rst_n.
REQ-002 Parameter DEPTH, default 4, SHALL set the result FIFO entries (power of two).
REQ-003 Parameter CNT_W, default 8, SHALL set the coarse counter width.
REQ-004 Parameter TIMEOUT, default 200, SHALL set the max window length in clk100 cycles; TIMEOUT SHALL satisfy 1 <= TIMEOUT <= 2^CNT_W.
REQ-005 clk100  in  1  measurement clock, 10 ns period.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 ena  in  1  controller enable.
REQ-008 evt_start  in  1  one-cycle pulse that opens a measurement window.
REQ-009 hit_valid  in  1  one-cycle pulse from the 4-phase fine sampler marking a stop hit.
REQ-010 hit_phase  in  2  fine phase code (0=0deg, 1=90deg, 2=180deg, 3=270deg), valid with hit_valid.
REQ-011 rd_ready  in  1  consumer accepts the head result.
REQ-012 clr_ovf  in  1  one-cycle pulse clearing the overflow flag.
REQ-013 rd_valid  out  1  head result available.
REQ-014 rd_data  out  CNT_W+3  {tmo, coarse[CNT_W-1:0], phase[1:0]}.
REQ-015 fifo_count  out  clog2(DEPTH)+1  stored results, 0..DEPTH.
REQ-016 busy  out  1  high when state is not IDLE.
REQ-017 overflow  out  1  sticky: a result was dropped on a full FIFO.

Function
REQ-018 The FSM SHALL have states IDLE, ARMED, STORE.
REQ-019 IDLE -> ARMED on evt_start=1 with ena=1; coarse SHALL load 0 in that cycle.
REQ-020 In ARMED, each cycle without hit or timeout, coarse SHALL increment by 1.
REQ-021 In ARMED with hit_valid=1: capture {tmo=0, coarse (pre-increment), hit_phase}, go to STORE; a hit on the first cycle after evt_start SHALL record coarse=0.
REQ-022 In ARMED with coarse==TIMEOUT-1 and hit_valid=0: capture {tmo=1, coarse=TIMEOUT-1, phase=0}, go to STORE.
REQ-023 hit_valid and timeout in the same cycle: hit SHALL win (tmo=0).
REQ-024 STORE SHALL last exactly one cycle: push the captured word if not full, else drop and set overflow; then go to IDLE.
REQ-025 evt_start in ARMED or STORE SHALL be ignored; hit_valid in IDLE or STORE SHALL be ignored.
REQ-026 ena=0 in ARMED SHALL abort to IDLE next cycle with no push; ena=0 in STORE SHALL NOT block the push.
REQ-027 FIFO SHALL be first-in first-out with wrap-around pointers; rd_valid = (fifo_count != 0); rd_data SHALL present the head word whenever rd_valid=1.
REQ-028 Pop SHALL occur on rd_valid & rd_ready; rd_ready with an empty FIFO SHALL have no effect.
REQ-029 Simultaneous push and pop SHALL keep fifo_count unchanged, including when full (push accepted, no overflow).
REQ-030 Latency: hit in cycle N -> STORE in N+1 -> rd_valid=1 in N+2 with an empty FIFO; IDLE in N+2, so a new evt_start is accepted from cycle N+2.
REQ-031 overflow SHALL clear on clr_ovf; a same-cycle set takes priority over clr_ovf.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, coarse=0, pointers=0, fifo_count=0, rd_valid=0, rd_data=0, busy=0, overflow=0, regardless of clock.
REQ-033 Reset mid-window or mid-STORE SHALL discard the capture; the first cycle after rst_n rises SHALL behave as IDLE.

Verification
REQ-034 evt_start at cycle 0, hit_valid with hit_phase=2 at cycle 4 -> rd_valid at cycle 6, rd_data={0, 3, 2}, fifo_count=1.
REQ-035 evt_start, no hit, TIMEOUT=200 -> STORE after 200 ARMED cycles, rd_data={1, 199, 0}, busy returns to 0.
REQ-036 Five windows each hit, rd_ready=0 -> fifo_count=4, overflow=1, first four results read back in order; clr_ovf -> overflow=0.
REQ-037 FIFO full, rd_ready=1 in the STORE cycle -> fifo_count stays 4, overflow stays 0, oldest popped, newest at tail.
REQ-038 Hit and timeout in the same cycle -> tmo=0, coarse=TIMEOUT-1; evt_start during ARMED ignored (coarse not reset).
REQ-039 rst_n low at mid-window with 2 entries stored -> all outputs 0 at once; after release, one full window yields a single correct entry.

Source files
------------

// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl -- time-to-digital measurement controller.
//
// A start event opens a window. A coarse counter counts clk100 cycles until
// a stop hit arrives from the 4-phase fine sampler, or until the window times
// out. The result word {tmo, coarse, phase} is pushed into a small result
// FIFO that the consumer drains with a valid/ready handshake.
//
// Ports:
//   clk100      measurement clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   ena         controller enable; dropping it in ARMED aborts the window
//   evt_start   one-cycle pulse that opens a window (accepted only in IDLE)
//   hit_valid   one-cycle stop-hit pulse (used only in ARMED)
//   hit_phase   fine phase code, valid with hit_valid
//   rd_ready    consumer accepts the head result
//   clr_ovf     one-cycle pulse clearing the overflow flag
//   rd_valid    head result available
//   rd_data     head result {tmo, coarse[CNT_W-1:0], phase[1:0]}, 0 when empty
//   fifo_count  number of stored results, 0..DEPTH
//   busy        controller is not in IDLE
//   overflow    sticky: a result was dropped because the FIFO was full
module tdc_meas_ctrl #(
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic                     clk100,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     evt_start,
    input  logic                     hit_valid,
    input  logic [1:0]               hit_phase,
    input  logic                     rd_ready,
    input  logic                     clr_ovf,
    output logic                     rd_valid,
    output logic [CNT_W+2:0]         rd_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     overflow
);

    localparam int W  = CNT_W + 3;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARMED, STORE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] coarse, coarse_nxt;
    logic [W-1:0]     cap, cap_nxt;

    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             full, push, pop, drop;

    // ---------------- controller FSM ----------------
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            coarse <= '0;
            cap    <= '0;
        end else begin
            state  <= state_nxt;
            coarse <= coarse_nxt;
            cap    <= cap_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        coarse_nxt = coarse;
        cap_nxt    = cap;
        unique case (state)
            IDLE: begin
                if (ena && evt_start) begin
                    state_nxt  = ARMED;
                    coarse_nxt = '0;
                end
            end
            ARMED: begin
                // Abort beats capture; a hit beats a timeout in the same cycle.
                if (!ena) begin
                    state_nxt = IDLE;
                end else if (hit_valid) begin
                    cap_nxt   = {1'b0, coarse, hit_phase};
                    state_nxt = STORE;
                end else if (coarse == TMO_LAST) begin
                    cap_nxt   = {1'b1, coarse, 2'b00};
                    state_nxt = STORE;
                end else begin
                    coarse_nxt = coarse + 1'b1;
                end
            end
            STORE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // ---------------- result FIFO ----------------
    assign rd_valid = (fifo_count != '0);
    assign full     = (fifo_count == CW'(DEPTH));
    assign pop      = rd_valid && rd_ready;
    // A pop in the STORE cycle frees a slot, so a full FIFO still accepts.
    assign push     = (state == STORE) && (!full || pop);
    assign drop     = (state == STORE) && full && !pop;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage needs no reset: rd_data is masked while the FIFO is empty.
    always_ff @(posedge clk100) begin
        if (push) mem[wr_ptr] <= cap;
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed testbench for tdc_meas_ctrl with default parameters
// (DEPTH=4, CNT_W=8, TIMEOUT=200). Inputs change 1 ns after a rising edge
// and outputs are checked there too, i.e. after the edge has taken effect.
module tb_tdc_meas_ctrl;

    logic        clk100, rst_n, ena, evt_start, hit_valid, rd_ready, clr_ovf;
    logic [1:0]  hit_phase;
    logic        rd_valid, busy, overflow;
    logic [10:0] rd_data;
    logic [2:0]  fifo_count;

    int total = 0;
    int passed = 0;

    tdc_meas_ctrl dut (
        .clk100     (clk100),
        .rst_n      (rst_n),
        .ena        (ena),
        .evt_start  (evt_start),
        .hit_valid  (hit_valid),
        .hit_phase  (hit_phase),
        .rd_ready   (rd_ready),
        .clr_ovf    (clr_ovf),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .fifo_count (fifo_count),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    function automatic logic [10:0] mk(input logic tmo, input logic [7:0] c, input logic [1:0] ph);
        return {tmo, c, ph};
    endfunction

    task automatic step();
        @(posedge clk100);
        #1;
    endtask

    // Open a window, hit after n ARMED cycles (coarse = n), run STORE and
    // land back in IDLE. pop_store drives rd_ready during the STORE cycle.
    task automatic window(input int n, input logic [1:0] ph, input bit pop_store);
        evt_start = 1'b1; step(); evt_start = 1'b0;
        repeat (n) step();
        hit_valid = 1'b1; hit_phase = ph; step(); hit_valid = 1'b0; hit_phase = 2'd0;
        rd_ready = pop_store; step(); rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; evt_start = 0; hit_valid = 0; hit_phase = 0;
        rd_ready = 0; clr_ovf = 0;
        #12;
        total++; if ({rd_valid, rd_data, fifo_count, busy, overflow} !== 17'd0)
            $display("FAIL reset_outputs: got %h need 0", {rd_valid, rd_data, fifo_count, busy, overflow});
        else passed++;
        #2 rst_n = 1'b1;
        step();
        total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b need 0", busy); else passed++;
    endtask

    task automatic test_basic();
        evt_start = 1'b1; step(); evt_start = 1'b0;           // cycle 1
        total++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b need 1", busy); else passed++;
        repeat (3) step();                                    // cycle 4
        hit_valid = 1'b1; hit_phase = 2'd2; step(); hit_valid = 1'b0; // cycle 5 STORE
        total++; if (rd_valid !== 1'b0) $display("FAIL basic_store_rdv: got %b need 0", rd_valid); else passed++;
        step();                                               // cycle 6
        total++; if (rd_valid !== 1'b1) $display("FAIL basic_rdv: got %b need 1", rd_valid); else passed++;
        total++; if (rd_data !== 11'h00E) $display("FAIL basic_data: got %h need 00e", rd_data); else passed++;
        total++; if (fifo_count !== 3'd1) $display("FAIL basic_count: got %0d need 1", fifo_count); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL basic_idle: got %b need 0", busy); else passed++;
        rd_ready = 1'b1; step(); step(); rd_ready = 1'b0;       // second pop on empty: no effect
        total++; if (fifo_count !== 3'd0 || rd_data !== 11'd0)
            $display("FAIL basic_pop: got cnt %0d data %h need 0 0", fifo_count, rd_data);
        else passed++;
    endtask

    task automatic test_timeout();
        evt_start = 1'b1; step(); evt_start = 1'b0;
        repeat (199) step();                                  // coarse 199, still ARMED
        total++; if (busy !== 1'b1) $display("FAIL tmo_armed: got %b need 1", busy); else passed++;
        step();                                               // STORE
        total++; if (busy !== 1'b1 || rd_valid !== 1'b0)
            $display("FAIL tmo_store: got busy %b rdv %b need 1 0", busy, rd_valid);
        else passed++;
        step();
        total++; if (rd_data !== mk(1'b1, 8'd199, 2'd0)) $display("FAIL tmo_data: got %h need %h", rd_data, mk(1'b1, 8'd199, 2'd0)); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL tmo_idle: got %b need 0", busy); else passed++;
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
    endtask

    task automatic test_tie_and_restart();
        evt_start = 1'b1; step(); evt_start = 1'b0;
        repeat (50) step();
        evt_start = 1'b1; step(); evt_start = 1'b0;           // ignored in ARMED
        repeat (148) step();                                  // coarse 199
        hit_valid = 1'b1; hit_phase = 2'd3; step(); hit_valid = 1'b0;
        step();
        total++; if (rd_data !== mk(1'b0, 8'd199, 2'd3)) $display("FAIL tie_data: got %h need %h", rd_data, mk(1'b0, 8'd199, 2'd3)); else passed++;
        total++; if (fifo_count !== 3'd1) $display("FAIL tie_count: got %0d need 1", fifo_count); else passed++;
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
    endtask

    task automatic test_ignore();
        evt_start = 1'b1; step(); evt_start = 1'b0; step();
        ena = 1'b0; step();
        total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b need 0", busy); else passed++;
        ena = 1'b1; hit_valid = 1'b1; step(); hit_valid = 1'b0; step();
        total++; if (busy !== 1'b0 || fifo_count !== 3'd0)
            $display("FAIL idle_hit: got busy %b cnt %0d need 0 0", busy, fifo_count);
        else passed++;
        ena = 1'b0; evt_start = 1'b1; step(); evt_start = 1'b0; ena = 1'b1;
        total++; if (busy !== 1'b0) $display("FAIL start_disabled: got %b need 0", busy); else passed++;
        // ena low during STORE must not block the push
        evt_start = 1'b1; step(); evt_start = 1'b0;
        hit_valid = 1'b1; hit_phase = 2'd1; step(); hit_valid = 1'b0;
        ena = 1'b0; step(); ena = 1'b1;
        total++; if (rd_data !== mk(1'b0, 8'd0, 2'd1) || fifo_count !== 3'd1)
            $display("FAIL store_ena0: got %h cnt %0d need %h 1", rd_data, fifo_count, mk(1'b0, 8'd0, 2'd1));
        else passed++;
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [10:0] exp;
        for (int i = 1; i <= 4; i++) window(i, 2'(i), 1'b0);
        total++; if (fifo_count !== 3'd4 || overflow !== 1'b0)
            $display("FAIL ovf_fill: got cnt %0d ovf %b need 4 0", fifo_count, overflow);
        else passed++;
        window(5, 2'd1, 1'b0);
        total++; if (fifo_count !== 3'd4 || overflow !== 1'b1)
            $display("FAIL ovf_set: got cnt %0d ovf %b need 4 1", fifo_count, overflow);
        else passed++;
        for (int i = 1; i <= 4; i++) begin
            exp = mk(1'b0, 8'(i), 2'(i));
            total++; if (rd_data !== exp) $display("FAIL ovf_read%0d: got %h need %h", i, rd_data, exp); else passed++;
            rd_ready = 1'b1; step(); rd_ready = 1'b0;
        end
        total++; if (rd_valid !== 1'b0 || overflow !== 1'b1)
            $display("FAIL ovf_drained: got rdv %b ovf %b need 0 1", rd_valid, overflow);
        else passed++;
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        total++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b need 0", overflow); else passed++;
    endtask

    task automatic test_full_push_pop();
        logic [7:0]  order [4];
        logic [10:0] exp;
        order = '{8'd2, 8'd3, 8'd4, 8'd6};
        for (int i = 1; i <= 4; i++) window(i, 2'd0, 1'b0);
        window(6, 2'd0, 1'b1);
        total++; if (fifo_count !== 3'd4 || overflow !== 1'b0)
            $display("FAIL full_pp: got cnt %0d ovf %b need 4 0", fifo_count, overflow);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            exp = mk(1'b0, order[i], 2'd0);
            total++; if (rd_data !== exp) $display("FAIL full_pp_read%0d: got %h need %h", i, rd_data, exp); else passed++;
            rd_ready = 1'b1; step(); rd_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        window(1, 2'd1, 1'b0);
        window(2, 2'd2, 1'b0);
        evt_start = 1'b1; step(); evt_start = 1'b0; repeat (3) step();
        #2 rst_n = 1'b0; #1;
        total++; if ({rd_valid, rd_data, fifo_count, busy, overflow} !== 17'd0)
            $display("FAIL midrst_outputs: got %h need 0", {rd_valid, rd_data, fifo_count, busy, overflow});
        else passed++;
        #1 rst_n = 1'b1;
        step();
        total++; if (busy !== 1'b0 || fifo_count !== 3'd0)
            $display("FAIL midrst_idle: got busy %b cnt %0d need 0 0", busy, fifo_count);
        else passed++;
        window(5, 2'd1, 1'b0);
        total++; if (fifo_count !== 3'd1 || rd_data !== mk(1'b0, 8'd5, 2'd1))
            $display("FAIL midrst_window: got cnt %0d data %h need 1 %h", fifo_count, rd_data, mk(1'b0, 8'd5, 2'd1));
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_tie_and_restart();
        test_ignore();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
